// File: rtl/tape_ram_arbiter_if.sv
// Host download and tape player handshake bundle for tape_ram_arbiter.
// The arbiter connects through the slave modport; host and player drive the master side.
interface tape_ram_arbiter_if #(
  parameter int AW = 18
);
  logic          dl_active;
  logic          dl_wr;
  logic [AW-1:0] dl_addr;
  logic [7:0]    dl_data;
  logic          dl_wait;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ack;
  logic [7:0]    rd_data;

  modport master (
    output dl_active, dl_wr, dl_addr, dl_data, rd_req, rd_addr,
    input  dl_wait, rd_ack, rd_data
  );

  modport slave (
    input  dl_active, dl_wr, dl_addr, dl_data, rd_req, rd_addr,
    output dl_wait, rd_ack, rd_data
  );
endinterface

// File: rtl/tape_ram_arbiter.sv
// Shares one single-port tape RAM between the host download writer and the tape player.
// Optional autoplay pulse after a download is built only when TAPE_AUTOPLAY_EN is defined.
module tape_ram_arbiter #(
  parameter int AW     = 18,
  parameter int RD_LAT = 2
) (
  input  logic          clock,
  input  logic          reset,
  tape_ram_arbiter_if.slave bus,
  output logic [AW-1:0] ram_a,
  output logic [7:0]    ram_d,
  input  logic [7:0]    ram_q,
  output logic          ram_we,
  output logic          ram_oe,
  output logic [AW-1:0] size,
  output logic          tape_hold,
  output logic          play,
  output logic [1:0]    state_dbg
);

  // Handshakes: dl_wr is accepted only while dl_wait is low and the host holds
  // address/data while dl_wait is high; rd_req is accepted only with no read
  // outstanding and is answered by exactly one rd_ack pulse carrying rd_data.

  typedef enum logic [1:0] {IDLE, WRITE, READ, RWAIT} state_t;

  localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

  state_t        state, state_n;
  logic          wr_pend, rd_pend, last_rd;
  logic [AW-1:0] wr_addr, rd_addr_q;
  logic [7:0]    wr_data, rd_data_q;
  logic          rd_ack_q;
  logic [1:0]    cnt;
  logic          grant_wr, grant_rd, rd_done;
  logic          dl_q, dl_rise, dl_fall;
  logic [AW:0]   max_r, max_n, wr_end;
  logic [AW-1:0] size_sat;

  assign grant_wr = wr_pend && (!rd_pend || last_rd);
  assign grant_rd = rd_pend && (!wr_pend || !last_rd);

  assign bus.dl_wait = wr_pend;
  assign bus.rd_ack  = rd_ack_q;
  assign bus.rd_data = rd_data_q;
  assign tape_hold   = dl_q;
  assign state_dbg   = state;

  always_comb begin
    state_n = state;
    ram_a   = '0;
    ram_d   = '0;
    ram_we  = 1'b0;
    ram_oe  = 1'b0;
    rd_done = 1'b0;
    case (state)
      IDLE: begin
        if (grant_wr)      state_n = WRITE;
        else if (grant_rd) state_n = READ;
      end
      WRITE: begin
        ram_a   = wr_addr;
        ram_d   = wr_data;
        ram_we  = 1'b1;
        state_n = IDLE;
      end
      READ: begin
        ram_a   = rd_addr_q;
        ram_oe  = 1'b1;
        state_n = RWAIT;
      end
      RWAIT: begin
        // Enable spans RD_LAT cycles; the final wait cycle only captures ram_q.
        ram_a  = rd_addr_q;
        ram_oe = (cnt != 2'd0);
        if (cnt == 2'd0) begin
          rd_done = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_pend   <= 1'b0;
      rd_pend   <= 1'b0;
      last_rd   <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      rd_ack_q  <= 1'b0;
    end else begin
      state    <= state_n;
      rd_ack_q <= rd_done;
      if (state == READ)                        cnt <= LAT_LOAD;
      else if (state == RWAIT && cnt != 2'd0)   cnt <= cnt - 2'd1;

      // The pending write is retired at grant so dl_wait drops in the WRITE cycle.
      if (state == IDLE && grant_wr) begin
        wr_pend <= 1'b0;
        last_rd <= 1'b0;
      end else if (bus.dl_wr && !wr_pend) begin
        wr_pend <= 1'b1;
        wr_addr <= bus.dl_addr;
        wr_data <= bus.dl_data;
      end

      if (rd_done) begin
        rd_pend   <= 1'b0;
        last_rd   <= 1'b1;
        rd_data_q <= ram_q;
      end else if (bus.rd_req && !rd_pend) begin
        rd_pend   <= 1'b1;
        rd_addr_q <= bus.rd_addr;
      end
    end
  end

  assign dl_rise = bus.dl_active && !dl_q;
  assign dl_fall = !bus.dl_active && dl_q;
  assign wr_end  = {1'b0, wr_addr} + (AW+1)'(1);

  always_comb begin
    max_n = dl_rise ? '0 : max_r;
    if (state == WRITE && wr_end > max_n) max_n = wr_end;
  end

  // A write still in flight at the falling edge is included in the final size.
  assign size_sat = max_n[AW] ? {AW{1'b1}} : max_n[AW-1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dl_q  <= 1'b0;
      max_r <= '0;
      size  <= '0;
    end else begin
      dl_q  <= bus.dl_active;
      max_r <= max_n;
      if (dl_fall) size <= size_sat;
    end
  end

`ifdef TAPE_AUTOPLAY_EN
  logic play_arm;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      play_arm <= 1'b0;
      play     <= 1'b0;
    end else begin
      play_arm <= dl_fall && (size_sat != '0);
      play     <= play_arm;
    end
  end
`else
  assign play = 1'b0;
`endif

endmodule

// File: tb/tb_tape_ram_arbiter.sv
// Directed bench for tape_ram_arbiter with a two-stage-latency RAM model (RD_LAT=2).
// Autoplay expectations follow TAPE_AUTOPLAY_EN.
module tb_tape_ram_arbiter;
  localparam int AW = 18;
`ifdef TAPE_AUTOPLAY_EN
  localparam bit AP = 1'b1;
`else
  localparam bit AP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] ram_a, size;
  logic [7:0]    ram_d, ram_q;
  logic          ram_we, ram_oe, tape_hold, play;
  logic [1:0]    state_dbg;
  int            n_checks = 0;
  int            n_errors = 0;

  tape_ram_arbiter_if #(.AW(AW)) bus();

  tape_ram_arbiter #(.AW(AW), .RD_LAT(2)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .ram_a(ram_a), .ram_d(ram_d), .ram_q(ram_q),
    .ram_we(ram_we), .ram_oe(ram_oe),
    .size(size), .tape_hold(tape_hold), .play(play), .state_dbg(state_dbg)
  );

  // ---- clock / RAM model ----
  always #5 clock = ~clock;

  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] p1, p2;
  always @(posedge clock) begin
    if (ram_we) mem[ram_a] <= ram_d;
    p1 <= ram_oe ? mem[ram_a] : 8'h00;
    p2 <= p1;
  end
  assign ram_q = p2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // ---- driver tasks ----
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [7:0] d);
    bus.dl_addr = a;
    bus.dl_data = d;
    bus.dl_wr   = 1'b1;
    tick();
    bus.dl_wr   = 1'b0;
    tick();
    tick();
  endtask

  task automatic drive_read(input logic [AW-1:0] a, output int ack_at,
                            output int oe_cycles, output logic [7:0] data);
    bus.rd_addr = a;
    bus.rd_req  = 1'b1;
    tick();
    bus.rd_req  = 1'b0;
    ack_at    = -1;
    oe_cycles = 0;
    data      = 8'h00;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      if (ram_oe) oe_cycles++;
      if (bus.rd_ack && ack_at < 0) begin
        ack_at = i;
        data   = bus.rd_data;
      end
    end
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    #1 reset = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({ram_we, ram_oe, bus.dl_wait, bus.rd_ack, tape_hold, play} !== 6'b0) begin
      n_errors++; $display("FAIL reset_strobes got %b want 000000",
                           {ram_we, ram_oe, bus.dl_wait, bus.rd_ack, tape_hold, play});
    end
    n_checks++;
    if (size !== '0 || ram_a !== '0 || bus.rd_data !== 8'h00) begin
      n_errors++; $display("FAIL reset_buses size=%h ram_a=%h rd_data=%h want 0", size, ram_a, bus.rd_data);
    end
    n_checks++;
    if (state_dbg !== 2'd0) begin
      n_errors++; $display("FAIL reset_state got %0d want 0", state_dbg);
    end
    @(negedge clock) reset = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    bus.dl_active = 1'b1;
    tick();
    n_checks++;
    if (tape_hold !== 1'b1) begin
      n_errors++; $display("FAIL tape_hold_rise got %b want 1", tape_hold);
    end
    bus.dl_addr = 18'h00010; bus.dl_data = 8'hA5; bus.dl_wr = 1'b1;
    tick();
    bus.dl_wr = 1'b0;
    n_checks++;
    if (bus.dl_wait !== 1'b1 || ram_we !== 1'b0) begin
      n_errors++; $display("FAIL wr_latch dl_wait=%b ram_we=%b want 1,0", bus.dl_wait, ram_we);
    end
    tick();
    n_checks++;
    if (bus.dl_wait !== 1'b0 || ram_we !== 1'b1 || ram_a !== 18'h00010 || ram_d !== 8'hA5) begin
      n_errors++; $display("FAIL wr_issue dl_wait=%b we=%b a=%h d=%h want 0,1,00010,a5",
                           bus.dl_wait, ram_we, ram_a, ram_d);
    end
    tick();
    n_checks++;
    if (ram_we !== 1'b0 || size !== '0) begin
      n_errors++; $display("FAIL wr_after we=%b size=%h want 0,0", ram_we, size);
    end
    bus.dl_active = 1'b0;
    tick();
    n_checks++;
    if (size !== 18'h00011 || tape_hold !== 1'b0) begin
      n_errors++; $display("FAIL wr_size size=%h hold=%b want 00011,0", size, tape_hold);
    end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      n_checks++;
      if (play !== (AP && k == 1)) begin
        n_errors++; $display("FAIL play_after_write k=%0d got %b want %b", k, play, (AP && k == 1));
      end
    end
  endtask

  task automatic test_single_read();
    int ack_at, oe_cycles;
    logic [7:0] d;
    drive_read(18'h00010, ack_at, oe_cycles, d);
    n_checks++;
    if (ack_at !== 4) begin
      n_errors++; $display("FAIL rd_latency got %0d want 4", ack_at);
    end
    n_checks++;
    if (d !== 8'hA5) begin
      n_errors++; $display("FAIL rd_data got %h want a5", d);
    end
    n_checks++;
    if (oe_cycles !== 2) begin
      n_errors++; $display("FAIL rd_oe_cycles got %0d want 2", oe_cycles);
    end
    n_checks++;
    if (bus.rd_ack !== 1'b0 || bus.rd_data !== 8'hA5) begin
      n_errors++; $display("FAIL rd_hold ack=%b data=%h want 0,a5", bus.rd_ack, bus.rd_data);
    end
  endtask

  task automatic test_collision();
    int ack_at, oe_cycles, we_at, wait_fall, oe_first;
    logic [AW-1:0] we_addr;
    logic [7:0] d;
    bus.dl_active = 1'b1;
    tick();
    do_write(18'h00009, 8'h77);
    drive_read(18'h00009, ack_at, oe_cycles, d);
    n_checks++;
    if (d !== 8'h77 || ack_at !== 4) begin
      n_errors++; $display("FAIL rd_during_dl data=%h at=%0d want 77,4", d, ack_at);
    end
    bus.dl_addr = 18'h00005; bus.dl_data = 8'h3C; bus.dl_wr = 1'b1;
    bus.rd_addr = 18'h00009; bus.rd_req = 1'b1;
    tick();
    bus.dl_wr = 1'b0; bus.rd_req = 1'b0;
    we_at = -1; wait_fall = -1; oe_first = -1; ack_at = -1; we_addr = '0; d = 8'h00;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      if (ram_we && we_at < 0) begin we_at = i; we_addr = ram_a; end
      if (!bus.dl_wait && wait_fall < 0) wait_fall = i;
      if (ram_oe && oe_first < 0) oe_first = i;
      if (bus.rd_ack && ack_at < 0) begin ack_at = i; d = bus.rd_data; end
    end
    n_checks++;
    if (we_at !== 1 || we_addr !== 18'h00005) begin
      n_errors++; $display("FAIL coll_write at=%0d addr=%h want 1,00005", we_at, we_addr);
    end
    n_checks++;
    if (oe_first !== 3 || ack_at !== 6) begin
      n_errors++; $display("FAIL coll_read oe_first=%0d ack=%0d want 3,6", oe_first, ack_at);
    end
    n_checks++;
    if (d !== 8'h77) begin
      n_errors++; $display("FAIL coll_data got %h want 77", d);
    end
    n_checks++;
    if (wait_fall !== 1) begin
      n_errors++; $display("FAIL coll_wait_fall got %0d want 1", wait_fall);
    end
    bus.dl_active = 1'b0;
    tick();
    n_checks++;
    if (size !== 18'h0000A) begin
      n_errors++; $display("FAIL coll_size got %h want 0000a", size);
    end
    tick(); tick(); tick();
  endtask

  task automatic test_size_max();
    bus.dl_active = 1'b1;
    tick();
    do_write(18'h3FFFF, 8'h11);
    n_checks++;
    if (size !== 18'h0000A) begin
      n_errors++; $display("FAIL size_frozen got %h want 0000a", size);
    end
    do_write(18'h00002, 8'h22);
    bus.dl_active = 1'b0;
    tick();
    n_checks++;
    if (size !== 18'h3FFFF) begin
      n_errors++; $display("FAIL size_saturate got %h want 3ffff", size);
    end
    tick(); tick(); tick();
    bus.dl_active = 1'b1;
    tick();
    tick();
    bus.dl_active = 1'b0;
    tick();
    n_checks++;
    if (size !== '0) begin
      n_errors++; $display("FAIL size_empty got %h want 0", size);
    end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      n_checks++;
      if (play !== 1'b0) begin
        n_errors++; $display("FAIL play_empty k=%0d got %b want 0", k, play);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int ack_cnt, ack_at, oe_cycles;
    logic [7:0] d;
    bus.dl_active = 1'b1;
    tick();
    do_write(18'h00020, 8'h5E);
    bus.dl_active = 1'b0;
    tick();
    n_checks++;
    if (size !== 18'h00021) begin
      n_errors++; $display("FAIL pre_reset_size got %h want 00021", size);
    end
    tick(); tick(); tick();
    bus.rd_addr = 18'h00020; bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    tick();
    tick();
    n_checks++;
    if (ram_oe !== 1'b1 || state_dbg !== 2'd3) begin
      n_errors++; $display("FAIL pre_reset_rwait oe=%b state=%0d want 1,3", ram_oe, state_dbg);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (ram_oe !== 1'b0 || state_dbg !== 2'd0 || size !== '0) begin
      n_errors++; $display("FAIL async_reset oe=%b state=%0d size=%h want 0,0,0", ram_oe, state_dbg, size);
    end
    ack_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.rd_ack) ack_cnt++;
    end
    @(negedge clock) reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.rd_ack) ack_cnt++;
    end
    n_checks++;
    if (ack_cnt !== 0 || state_dbg !== 2'd0) begin
      n_errors++; $display("FAIL reset_abort acks=%0d state=%0d want 0,0", ack_cnt, state_dbg);
    end
    drive_read(18'h00020, ack_at, oe_cycles, d);
    n_checks++;
    if (ack_at !== 4 || d !== 8'h5E) begin
      n_errors++; $display("FAIL post_reset_read at=%0d data=%h want 4,5e", ack_at, d);
    end
  endtask

  task automatic test_autoplay();
    logic [7:0] b;
    bus.dl_active = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) begin
      b = 8'(i) ^ 8'h5A;
      do_write(AW'(i), b);
    end
    bus.dl_active = 1'b0;
    tick();
    n_checks++;
    if (size !== 18'd100) begin
      n_errors++; $display("FAIL autoplay_size got %0d want 100", size);
    end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      n_checks++;
      if (play !== (AP && k == 1)) begin
        n_errors++; $display("FAIL autoplay_pulse k=%0d got %b want %b", k, play, (AP && k == 1));
      end
    end
  endtask

  initial begin
    bus.dl_active = 1'b0; bus.dl_wr = 1'b0; bus.dl_addr = '0; bus.dl_data = '0;
    bus.rd_req = 1'b0; bus.rd_addr = '0;
    test_reset();
    test_single_write();
    test_single_read();
    test_collision();
    test_size_max();
    test_reset_mid_read();
    test_autoplay();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
